// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope generator.
package adsr_pkg;

  localparam int unsigned DEFAULT_ENV_WIDTH = 32;
  localparam int unsigned STATE_WIDTH       = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_e;

  // Full-scale envelope value (Q1.31 style 1.0) for a given word width.
  function automatic longint unsigned env_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/env_sat_step.sv
// Saturating add/subtract toward a limit; flags when the limit is reached.
module env_sat_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             add,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] next_c,
  output logic             reached_c
);

  localparam int unsigned XW = WIDTH + 1;

  logic        [XW-1:0] sum;
  logic signed [XW-1:0] diff;

  // One extra bit keeps the sum from wrapping and the difference signed.
  always_comb begin
    sum       = XW'(cur) + XW'(step);
    diff      = signed'(XW'(cur) - XW'(step));
    next_c    = cur;
    reached_c = 1'b0;
    if (add) begin
      if (step == '0 || sum >= XW'(limit)) begin
        next_c    = limit;
        reached_c = 1'b1;
      end else begin
        next_c = WIDTH'(sum);
      end
    end else begin
      if (step == '0 || diff <= signed'(XW'(limit))) begin
        next_c    = limit;
        reached_c = 1'b1;
      end else begin
        next_c = WIDTH'(diff);
      end
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator; advances one step per sample_tick.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int unsigned ENVELOPE_WIDTH = DEFAULT_ENV_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic                      gate,
  input  logic [ENVELOPE_WIDTH-1:0] attack_step,
  input  logic [ENVELOPE_WIDTH-1:0] decay_step,
  input  logic [ENVELOPE_WIDTH-1:0] sustain_level,
  input  logic [ENVELOPE_WIDTH-1:0] release_step,
  output logic [ENVELOPE_WIDTH-1:0] envelope_out,
  output logic                      envelope_valid,
  output logic [STATE_WIDTH-1:0]    state_out,
  output logic                      active
);

  localparam logic [ENVELOPE_WIDTH-1:0] ENV_MAX = ENVELOPE_WIDTH'(env_max(ENVELOPE_WIDTH));

  adsr_state_e               state_q, state_d, op_state_c;
  logic [ENVELOPE_WIDTH-1:0] env_q, env_d;
  logic [ENVELOPE_WIDTH-1:0] sustain_c, step_c, limit_c, next_c;
  logic                      reached_c, rise_c, fall_c;
  logic                      gate_prev_q, valid_q, active_q;

  // Gate edges pick the state whose rule applies on this tick.
  always_comb begin
    sustain_c  = (sustain_level > ENV_MAX) ? ENV_MAX : sustain_level;
    rise_c     = gate & ~gate_prev_q;
    fall_c     = ~gate & gate_prev_q;
    op_state_c = state_q;
    if (rise_c) begin
      op_state_c = ATTACK;
    end else if (fall_c && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
      op_state_c = RELEASE;
    end
    step_c  = '0;
    limit_c = '0;
    case (op_state_c)
      ATTACK:  begin step_c = attack_step;  limit_c = ENV_MAX;   end
      DECAY:   begin step_c = decay_step;   limit_c = sustain_c; end
      RELEASE: begin step_c = release_step; limit_c = '0;        end
      default: ;
    endcase
  end

  env_sat_step #(
    .WIDTH(ENVELOPE_WIDTH)
  ) u_step (
    .add      (op_state_c == ATTACK),
    .cur      (env_q),
    .step     (step_c),
    .limit    (limit_c),
    .next_c   (next_c),
    .reached_c(reached_c)
  );

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (sample_tick) begin
      state_d = op_state_c;
      case (op_state_c)
        IDLE: env_d = '0;
        ATTACK: begin
          env_d = next_c;
          if (reached_c) state_d = DECAY;
        end
        DECAY: begin
          env_d = next_c;
          if (reached_c) state_d = SUSTAIN;
        end
        SUSTAIN: env_d = sustain_c;
        RELEASE: begin
          env_d = next_c;
          if (reached_c) state_d = IDLE;
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      env_q       <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      gate_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      valid_q  <= sample_tick;
      active_q <= (state_d != IDLE);
      if (sample_tick) gate_prev_q <= gate;
    end
  end

  assign envelope_out   = env_q;
  assign envelope_valid = valid_q;
  assign state_out      = state_q;
  assign active         = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed scenarios plus randomized ticks vs a reference model.
module tb_adsr_envelope;

  localparam int unsigned W   = 32;
  localparam longint      MAX = 64'h7FFF_FFFF;

  logic         clk = 1'b0;
  logic         rst, sample_tick, gate;
  logic [W-1:0] attack_step, decay_step, sustain_level, release_step;
  logic [W-1:0] envelope_out;
  logic         envelope_valid;
  logic [2:0]   state_out;
  logic         active;

  int checks = 0;
  int errors = 0;

  longint m_env;
  int     m_state;
  bit     m_gp;

  adsr_envelope #(.ENVELOPE_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .envelope_out  (envelope_out),
    .envelope_valid(envelope_valid),
    .state_out     (state_out),
    .active        (active)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] obs();
    return {envelope_out, state_out, envelope_valid, active};
  endfunction

  function automatic logic [36:0] exp_word(input longint e, input int s, input bit v);
    return {32'(e), 3'(s), v, s != 0};
  endfunction

  task automatic model_reset();
    m_env = 0; m_state = 0; m_gp = 0;
  endtask

  // Reference: states 0..4 = idle, attack, decay, sustain, release.
  task automatic model_step();
    longint sus, a, d, r;
    bit rise, fall;
    sus  = (longint'(sustain_level) > MAX) ? MAX : longint'(sustain_level);
    a    = longint'(attack_step);
    d    = longint'(decay_step);
    r    = longint'(release_step);
    rise = gate && !m_gp;
    fall = !gate && m_gp;
    m_gp = gate;
    if (rise) m_state = 1;
    else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
    case (m_state)
      0: m_env = 0;
      1: if (a == 0 || m_env + a >= MAX) begin m_env = MAX; m_state = 2; end
         else m_env = m_env + a;
      2: if (d == 0 || m_env - d <= sus) begin m_env = sus; m_state = 3; end
         else m_env = m_env - d;
      3: m_env = sus;
      default: if (r == 0 || m_env - r <= 0) begin m_env = 0; m_state = 0; end
               else m_env = m_env - r;
    endcase
  endtask

  task automatic tick();
    model_step();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_tick = 1'b0; gate = 1'b0;
    attack_step = '0; decay_step = '0; sustain_level = '0; release_step = '0;
    wait_cycles(3);
    rst = 1'b0;
    model_reset();
    checks++;
    if (obs() !== exp_word(0, 0, 0)) begin
      errors++; $display("FAIL reset: got %h expected %h", obs(), exp_word(0, 0, 0));
    end
  endtask

  task automatic test_attack();
    longint exp_env [4] = '{64'h2000_0000, 64'h4000_0000, 64'h6000_0000, 64'h7FFF_FFFF};
    int     exp_st  [4] = '{1, 1, 1, 2};
    gate = 1'b1; attack_step = 32'h2000_0000; decay_step = 32'h1000_0000;
    sustain_level = 32'h4000_0000; release_step = 32'h1800_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs() !== exp_word(exp_env[i], exp_st[i], 1)) begin
        errors++; $display("FAIL attack[%0d]: got %h expected %h", i, obs(), exp_word(exp_env[i], exp_st[i], 1));
      end
      wait_cycles(1);
      checks++;
      if (obs() !== exp_word(exp_env[i], exp_st[i], 0)) begin
        errors++; $display("FAIL attack_hold[%0d]: got %h expected %h", i, obs(), exp_word(exp_env[i], exp_st[i], 0));
      end
      wait_cycles(6);
    end
  endtask

  task automatic test_decay_sustain();
    longint exp_env [6] = '{64'h6FFF_FFFF, 64'h5FFF_FFFF, 64'h4FFF_FFFF, 64'h4000_0000,
                            64'h3000_0000, 64'h4000_0000};
    int     exp_st  [6] = '{2, 2, 2, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      if (i == 4) sustain_level = 32'h3000_0000;
      if (i == 5) sustain_level = 32'h4000_0000;
      tick();
      checks++;
      if (obs() !== exp_word(exp_env[i], exp_st[i], 1)) begin
        errors++; $display("FAIL decay[%0d]: got %h expected %h", i, obs(), exp_word(exp_env[i], exp_st[i], 1));
      end
      wait_cycles(3);
    end
  endtask

  task automatic test_release();
    longint exp_env [3] = '{64'h2800_0000, 64'h1000_0000, 64'h0};
    int     exp_st  [3] = '{4, 4, 0};
    gate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== exp_word(exp_env[i], exp_st[i], 1)) begin
        errors++; $display("FAIL release[%0d]: got %h expected %h", i, obs(), exp_word(exp_env[i], exp_st[i], 1));
      end
      wait_cycles(2);
    end
  endtask

  task automatic test_retrigger();
    bit           g   [5] = '{1, 1, 0, 1, 1};
    logic [W-1:0] atk [5] = '{32'h0, 32'h0, 32'h0, 32'h4000_0000, 32'h4000_0000};
    longint exp_env [5] = '{64'h7FFF_FFFF, 64'h4000_0000, 64'h2800_0000, 64'h6800_0000, 64'h7FFF_FFFF};
    int     exp_st  [5] = '{2, 3, 4, 1, 2};
    decay_step = '0; sustain_level = 32'h4000_0000; release_step = 32'h1800_0000;
    for (int i = 0; i < 5; i++) begin
      gate = g[i]; attack_step = atk[i];
      tick();
      checks++;
      if (obs() !== exp_word(exp_env[i], exp_st[i], 1)) begin
        errors++; $display("FAIL retrigger[%0d]: got %h expected %h", i, obs(), exp_word(exp_env[i], exp_st[i], 1));
      end
      wait_cycles(2);
    end
  endtask

  task automatic test_zero_steps();
    sustain_level = 32'hFFFF_FFFF; decay_step = 32'h1000_0000;
    tick();
    checks++;
    if (obs() !== exp_word(MAX, 3, 1)) begin
      errors++; $display("FAIL sustain_clamp: got %h expected %h", obs(), exp_word(MAX, 3, 1));
    end
    wait_cycles(2);
    release_step = '0; gate = 1'b0;
    tick();
    checks++;
    if (obs() !== exp_word(0, 0, 1)) begin
      errors++; $display("FAIL release_zero: got %h expected %h", obs(), exp_word(0, 0, 1));
    end
    wait_cycles(1);
    gate = 1'b1;
    wait_cycles(2);
    gate = 1'b0;
    wait_cycles(1);
    tick();
    checks++;
    if (obs() !== exp_word(0, 0, 1)) begin
      errors++; $display("FAIL gate_glitch: got %h expected %h", obs(), exp_word(0, 0, 1));
    end
    wait_cycles(2);
  endtask

  task automatic test_reset_mid();
    attack_step = 32'h2000_0000; gate = 1'b1;
    tick(); wait_cycles(2);
    tick();
    checks++;
    if (obs() !== exp_word(64'h4000_0000, 1, 1)) begin
      errors++; $display("FAIL pre_reset: got %h expected %h", obs(), exp_word(64'h4000_0000, 1, 1));
    end
    wait_cycles(2);
    rst = 1'b1; sample_tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; sample_tick = 1'b0;
    model_reset();
    checks++;
    if (obs() !== exp_word(0, 0, 0)) begin
      errors++; $display("FAIL reset_mid: got %h expected %h", obs(), exp_word(0, 0, 0));
    end
    wait_cycles(2);
    tick();
    checks++;
    if (obs() !== exp_word(64'h2000_0000, 1, 1)) begin
      errors++; $display("FAIL post_reset_rise: got %h expected %h", obs(), exp_word(64'h2000_0000, 1, 1));
    end
    wait_cycles(2);
  endtask

  function automatic logic [W-1:0] rand_step();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return W'($urandom);
      default: return W'($urandom_range(0, 32'h0800_0000));
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) attack_step  = rand_step();
      if ($urandom_range(0, 4) == 0) decay_step   = rand_step();
      if ($urandom_range(0, 4) == 0) release_step = rand_step();
      if ($urandom_range(0, 6) == 0)
        sustain_level = ($urandom_range(0, 4) == 0) ? W'($urandom) : W'($urandom_range(0, 32'h7FFF_FFFF));
      if ($urandom_range(0, 5) == 0) gate = ~gate;
      tick();
      checks++;
      if (obs() !== exp_word(m_env, m_state, 1)) begin
        errors++; $display("FAIL random_tick[%0d]: got %h expected %h", i, obs(), exp_word(m_env, m_state, 1));
      end
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        if ($urandom_range(0, 7) == 0) gate = ~gate;
        wait_cycles(1);
        checks++;
        if (obs() !== exp_word(m_env, m_state, 0)) begin
          errors++; $display("FAIL random_hold[%0d]: got %h expected %h", i, obs(), exp_word(m_env, m_state, 0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_decay_sustain();
    test_release();
    test_retrigger();
    test_zero_steps();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
Per-voice ADSR envelope generator that produces the unsigned Q1.31 gain word consumed by the voice's envelope mixer on its envelope_in port. Full scale is 32'h7FFF_FFFF, which the mixer treats as 1.0. The block advances one step per sample_tick, driven by a note gate, with programmable rate and sustain inputs. Its state is visible for voice allocation.

Parameters:
ENVELOPE_WIDTH, 32, width of envelope, step and sustain words; full scale ENV_MAX = 2^(ENVELOPE_WIDTH-1)-1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sample_tick  input  1  one-cycle strobe at the audio sample rate; all updates occur only on tick cycles
gate  input  1  note on (1) / note off (0); sampled only on tick cycles
attack_step  input  ENVELOPE_WIDTH  increment per tick in ATTACK; 0 means instant
decay_step  input  ENVELOPE_WIDTH  decrement per tick in DECAY; 0 means instant
sustain_level  input  ENVELOPE_WIDTH  sustain target; values above ENV_MAX are clamped to ENV_MAX
release_step  input  ENVELOPE_WIDTH  decrement per tick in RELEASE; 0 means instant
envelope_out  output  ENVELOPE_WIDTH  current envelope, unsigned, never exceeds ENV_MAX
envelope_valid  output  1  one-cycle pulse when envelope_out updates
state_out  output  3  current state encoding from the package
active  output  1  high whenever state is not IDLE

Behaviour:
- Reset values: envelope_out=0, envelope_valid=0, state=IDLE, active=0, gate_prev=0.
- Latency: on a tick in cycle N, the new envelope_out, state_out and active are visible at cycle N+1, and envelope_valid=1 in cycle N+1 only.
  - envelope_valid pulses on every tick, including IDLE and SUSTAIN ticks.
  - Non-tick cycles hold every output unchanged; envelope_valid=0.
- gate_prev is updated to gate on every tick.
  - rise = gate & ~gate_prev
  - fall = ~gate & gate_prev
  - Gate pulses shorter than the tick spacing are ignored.
- Per-tick priority, highest first: rise, then fall, then normal progression.
- Transition on rise, from any state: go to ATTACK (retrigger from the current level, with no reset to 0). The first step is applied on this same tick.
- Transition on fall, in ATTACK, DECAY or SUSTAIN: go to RELEASE. The first release step is applied on this same tick.
- Normal progression, by state:
  - IDLE: envelope holds 0.
  - ATTACK: sum = env + attack_step, computed in ENVELOPE_WIDTH+1 bits. If attack_step==0 or sum >= ENV_MAX, then env=ENV_MAX and state goes to DECAY; otherwise env=sum.
  - DECAY: target = clamped sustain_level. If decay_step==0 or env - decay_step <= target (signed compare, ENVELOPE_WIDTH+1 bits), then env=target and state goes to SUSTAIN; otherwise env = env - decay_step.
  - SUSTAIN: env = clamped sustain_level every tick, so live sustain edits track immediately.
  - RELEASE: if release_step==0 or env - release_step <= 0, then env=0 and state goes to IDLE; otherwise env = env - release_step.
- Arithmetic saturates: no wrap-around in either direction.
- Fall while in IDLE or RELEASE: no effect.
- Reset asserted mid-envelope: all outputs return to reset values on the next cycle, with no ramp-down.
- sample_tick and rst in the same cycle: rst wins.

Decomposition:
- Shared package adsr_pkg holds:
  - the state enum: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
  - the ENV_MAX constant function of width
- One sub-module is natural: env_sat_step.
  - Combinational saturating add/subtract with a target clamp.
  - Returns the next value plus a reached flag.
  - Instantiated once, with operation selected by state.

Test Plan:
- Attack, default width: after reset, gate=1, attack_step=32'h2000_0000, one tick per 8 cycles.
  - Required: envelope sequence 2000_0000, 4000_0000, 6000_0000, 7FFF_FFFF.
  - State goes to DECAY on the 4th tick; envelope_valid pulses once per tick, one cycle late.
- Decay into sustain: continue with decay_step=32'h1000_0000, sustain_level=32'h4000_0000.
  - Required: 6FFF_FFFF, 5FFF_FFFF, 4FFF_FFFF, then 4000_0000 (clamped) with state SUSTAIN.
  - Changing sustain to 32'h3000_0000 gives 3000_0000 on the next tick.
- Release to idle: from sustain 4000_0000, drop gate with release_step=32'h1800_0000.
  - Required: 2800_0000, 1000_0000, then 0 with state IDLE and active=0.
- Retrigger during release: raise gate at envelope 2800_0000 with attack_step=32'h4000_0000.
  - Required: next value 6800_0000 in ATTACK, then 7FFF_FFFF in DECAY (no restart from 0).
- Zero steps and clamps:
  - attack_step=0 gives 7FFF_FFFF on the first tick.
  - sustain_level=32'hFFFF_FFFF gives SUSTAIN at 7FFF_FFFF.
  - release_step=0 gives 0 on one tick.
  - A gate pulse between ticks causes no change.
- Reset mid-ATTACK at 4000_0000: next cycle envelope_out=0, state IDLE, envelope_valid=0. A tick coincident with rst is ignored.
